// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-pattern detector with run-time pattern reload,
// overlap selection, a registered match pulse and a saturating match counter.
module seq_detector_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b1011)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic             in_i,
  input  logic             pat_load_i,
  input  logic [PAT_W-1:0] pat_in_i,
  input  logic             overlap_i,
  input  logic             cnt_clr_i,
  output logic             out_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic             cnt_sat_o
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic [PAT_W-1:0] hist_n;
  logic [FW-1:0]    fill_n;
  logic             match;
  logic [CNT_W-1:0] cnt_base;
  logic             sat_base;

  always_comb begin
    hist_n = {hist_q[PAT_W-2:0], in_i};
    fill_n = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
    match  = in_valid_i && !pat_load_i &&
             (fill_n == FILL_MAX) && (hist_n == pat_q);

    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    out_d  = match;

    if (pat_load_i) begin
      pat_d  = pat_in_i;
      fill_d = '0;
    end else if (in_valid_i) begin
      hist_d = hist_n;
      // Non-overlapping mode flushes so the next match needs fresh bits
      fill_d = (match && !overlap_i) ? '0 : fill_n;
    end

    cnt_base = cnt_clr_i ? '0 : cnt_q;
    sat_base = cnt_clr_i ? 1'b0 : sat_q;
    cnt_d    = cnt_base;
    if (match && (cnt_base != CNT_MAX))
      cnt_d = cnt_base + 1'b1;
    sat_d = sat_base | (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pat_q  <= DEFAULT_PAT;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  assign out_o       = out_q;
  assign match_cnt_o = cnt_q;
  assign cnt_sat_o   = sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vector table then random stream
// compared against a queue-based reference model.
module tb_seq_detector_param;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam logic [PAT_W-1:0] DEF = 4'b1011;

  logic             clk = 1'b0;
  logic             rst, vld, din, ld, ovl, clr;
  logic [PAT_W-1:0] pin;
  logic             out;
  logic [CNT_W-1:0] cnt;
  logic             sat;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_detector_param #(
    .PAT_W(PAT_W), .CNT_W(CNT_W), .DEFAULT_PAT(DEF)
  ) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(vld), .in_i(din),
    .pat_load_i(ld), .pat_in_i(pin), .overlap_i(ovl),
    .cnt_clr_i(clr), .out_o(out), .match_cnt_o(cnt), .cnt_sat_o(sat)
  );

  typedef struct {
    bit r, v, b, l;
    logic [PAT_W-1:0] p;
    bit o, c;
    bit eo;
    int ec;
    bit es;
  } vec_t;

  vec_t tbl[$];

  // reference model: bits since last flush, bounded to PAT_W
  bit               mq[$];
  logic [PAT_W-1:0] mpat;
  int               mcnt;
  bit               msat, mout;

  function automatic void model_step(bit r, bit v, bit b, bit l,
                                     logic [PAT_W-1:0] p, bit o, bit c);
    bit m;
    int val;
    m = 0;
    if (r) begin
      mpat = DEF; mq.delete(); mout = 0; mcnt = 0; msat = 0;
      return;
    end
    if (l) begin
      mpat = p;
      mq.delete();
    end else if (v) begin
      mq.push_back(b);
      if (mq.size() > PAT_W) void'(mq.pop_front());
      if (mq.size() == PAT_W) begin
        val = 0;
        for (int k = 0; k < PAT_W; k++)
          val = val * 2 + int'(mq[k]);
        m = (val == int'(mpat));
        if (m && !o) mq.delete();
      end
    end
    if (c) begin
      mcnt = 0; msat = 0;
    end
    if (m && mcnt < CMAX) begin
      mcnt++;
      if (mcnt == CMAX) msat = 1;
    end
    mout = m;
  endfunction

  task automatic check(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(bit r, bit v, bit b, bit l,
                      logic [PAT_W-1:0] p, bit o, bit c);
    rst = r; vld = v; din = b; ld = l; pin = p; ovl = o; clr = c;
    model_step(r, v, b, l, p, o, c);
    @(posedge clk);
    #1;
  endtask

  function automatic void add(bit r, bit v, bit b, bit l,
                              logic [PAT_W-1:0] p, bit o, bit c,
                              bit eo, int ec, bit es);
    vec_t t;
    t.r = r; t.v = v; t.b = b; t.l = l; t.p = p; t.o = o; t.c = c;
    t.eo = eo; t.ec = ec; t.es = es;
    tbl.push_back(t);
  endfunction

  function automatic void R();
    add(1, 0, 0, 0, 4'h0, 1, 0, 0, 0, 0);
  endfunction

  function automatic void B(bit b, bit o, bit eo, int ec, bit es);
    add(0, 1, b, 0, 4'h0, o, 0, eo, ec, es);
  endfunction

  initial begin
    rst = 1; vld = 0; din = 0; ld = 0; pin = '0; ovl = 1; clr = 0;

    // reset then default pattern
    R(); R();
    B(1,1,0,0,0); B(0,1,0,0,0); B(1,1,0,0,0); B(1,1,1,1,0);
    // overlapping 1011011
    R();
    B(1,1,0,0,0); B(0,1,0,0,0); B(1,1,0,0,0); B(1,1,1,1,0);
    B(0,1,0,1,0); B(1,1,0,1,0); B(1,1,1,2,0);
    // non-overlapping 1011011 then 1011
    R();
    B(1,0,0,0,0); B(0,0,0,0,0); B(1,0,0,0,0); B(1,0,1,1,0);
    B(0,0,0,1,0); B(1,0,0,1,0); B(1,0,0,1,0);
    B(1,0,0,1,0); B(0,0,0,1,0); B(1,0,0,1,0); B(1,0,1,2,0);
    // gaps
    R();
    B(1,1,0,0,0); B(0,1,0,0,0);
    add(0,0,1,0,4'h0,1,0,0,0,0);
    add(0,0,1,0,4'h0,1,0,0,0,0);
    add(0,0,1,0,4'h0,1,0,0,0,0);
    B(1,1,0,0,0); B(1,1,1,1,0);
    // pattern 0000, zero-filled hist must not match early; saturation
    R();
    add(0,1,0,1,4'b0000,1,0,0,0,0);
    B(0,1,0,0,0); B(0,1,0,0,0); B(0,1,0,0,0);
    B(0,1,1,1,0); B(0,1,1,2,0); B(0,1,1,3,1); B(0,1,1,3,1);
    add(0,1,0,0,4'h0,1,1,1,1,0);
    add(0,0,0,0,4'h0,1,1,0,0,0);
    // pattern load mid-stream discards the load-cycle bit
    R();
    B(1,1,0,0,0); B(0,1,0,0,0); B(1,1,0,0,0);
    add(0,1,1,1,4'b0110,1,0,0,0,0);
    B(0,1,0,0,0); B(1,1,0,0,0); B(1,1,0,0,0); B(0,1,1,1,0);
    // mid-stream reset
    R();
    B(1,1,0,0,0); B(0,1,0,0,0); B(1,1,0,0,0);
    R();
    B(1,1,0,0,0); B(0,1,0,0,0); B(1,1,0,0,0); B(1,1,1,1,0);
    // counter saturation then clear coinciding with a match
    R();
    B(1,1,0,0,0); B(0,1,0,0,0); B(1,1,0,0,0); B(1,1,1,1,0);
    B(0,1,0,1,0); B(1,1,0,1,0); B(1,1,1,2,0);
    B(0,1,0,2,0); B(1,1,0,2,0); B(1,1,1,3,1);
    B(0,1,0,3,1); B(1,1,0,3,1); B(1,1,1,3,1);
    B(0,1,0,3,1); B(1,1,0,3,1);
    add(0,1,1,0,4'h0,1,1,1,1,0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].b, tbl[i].l,
           tbl[i].p, tbl[i].o, tbl[i].c);
      check($sformatf("vec%0d.out", i), int'(out), int'(tbl[i].eo));
      check($sformatf("vec%0d.cnt", i), int'(cnt), tbl[i].ec);
      check($sformatf("vec%0d.sat", i), int'(sat), int'(tbl[i].es));
    end

    for (int i = 0; i < 3000; i++) begin
      bit r, v, b, l, o, c;
      logic [PAT_W-1:0] p;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      b = 1'($urandom);
      l = ($urandom_range(0, 39) == 0);
      p = PAT_W'($urandom);
      o = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 29) == 0);
      step(r, v, b, l, p, o, c);
      check("rnd.out", int'(out), int'(mout));
      check("rnd.cnt", int'(cnt), mcnt);
      check("rnd.sat", int'(sat), int'(msat));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
